// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared state encoding, defaults and one-hot helper for the fifo write arbiter
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_BURST = 4;

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: rotating-priority encoder, first set request at or after rr_ptr
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int W     = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     rr_ptr,
    output logic [W-1:0]     idx,
    output logic             found
);

    logic [W-1:0] cand;

    function automatic int wrap(input int s);
        return s >= N_REQ ? s - N_REQ : s;
    endfunction

    // scan from farthest to nearest so the closest requester after rr_ptr wins
    always_comb begin
        idx   = '0;
        cand  = '0;
        found = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = W'(wrap(int'(rr_ptr) + k));
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of the fifo write port with bounded bursts
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_wd,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy,
    output logic                WREQ,
    output logic [DW-1:0]       WD,
    input  logic                f
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t           state, state_n;
    logic [OW-1:0]    owner, owner_n, rr_ptr, rr_ptr_n, pick_idx;
    logic [CW-1:0]    cnt, cnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic             pick_found;

    rr_pick #(.N_REQ(N_REQ), .W(OW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // write port is driven straight from registered state so reset clears it at once
    always_comb begin
        busy = state == GRANT;
        WREQ = busy & req[owner] & ~f;
        ack  = WREQ ? gnt : '0;
        WD   = '0;
        for (int i = 0; i < N_REQ; i++)
            if (busy && owner == OW'(i)) WD = req_wd[i*DW +: DW];
    end

    // arbitration in IDLE; burst counting and release in GRANT
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        cnt_n    = cnt;
        gnt_n    = gnt;
        if (state == IDLE) begin
            if (pick_found) begin
                state_n = GRANT;
                owner_n = pick_idx;
                cnt_n   = '0;
                gnt_n   = N_REQ'(onehot(4'(pick_idx)));
            end
        end else if (!req[owner] || (WREQ && cnt == CW'(MAX_BURST - 1))) begin
            state_n  = IDLE;
            gnt_n    = '0;
            cnt_n    = '0;
            rr_ptr_n = owner == OW'(N_REQ - 1) ? '0 : owner + OW'(1);
        end else if (WREQ) begin
            cnt_n = cnt + CW'(1);
        end
    end

    // state register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            gnt    <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr_ptr <= rr_ptr_n;
            cnt    <= cnt_n;
            gnt    <= gnt_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized scoreboard bench for the fifo write arbiter
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 0, rst = 1, f = 0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_wd = '0;
    logic [N-1:0]    ack, gnt;
    logic            busy, WREQ;
    logic [DW-1:0]   WD;

    typedef struct {int who; logic [DW-1:0] data;} wr_t;
    wr_t exp_q[$];
    wr_t e;

    int checks = 0, errors = 0;
    int m_busy, m_owner, m_ptr, m_cnt;
    logic [N-1:0] exp_gnt = '0;
    logic         exp_busy = 0;
    logic [N-1:0] r;
    logic         ff;

    fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wd(req_wd), .ack(ack),
        .gnt(gnt), .busy(busy), .WREQ(WREQ), .WD(WD), .f(f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        exp_gnt = '0; exp_busy = 0;
    endtask

    task automatic model_release();
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
        m_cnt  = 0;
    endtask

    // what the arbiter must do on a clock edge given the inputs held during the cycle
    task automatic model_edge();
        bit done = 0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++)
                if (!done && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_busy  = 1;
                    m_cnt   = 0;
                    done    = 1;
                end
        end else if (!req[m_owner]) begin
            model_release();
        end else if (!f) begin
            m_cnt++;
            if (m_cnt == MB) model_release();
        end
    endtask

    task automatic step(input logic [N-1:0] nr, input logic nf);
        @(posedge clk);
        model_edge();
        #1;
        req    = nr;
        f      = nf;
        req_wd = N*DW'($urandom);
        exp_busy = m_busy != 0;
        exp_gnt  = m_busy ? N'(1 << m_owner) : '0;
        if (m_busy && req[m_owner] && !f) exp_q.push_back('{m_owner, req_wd[m_owner*DW +: DW]});
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        model_edge();
        #3 rst = 1;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wreq", 32'(WREQ), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1 rst = 0;
    endtask

    // monitor: compare grant state every cycle and pop expected words when the fifo is written
    always @(negedge clk) begin
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("gnt_onehot", 32'($onehot0(gnt)), 1);
        chk("ack_sub_gnt", 32'(ack & ~gnt), 0);
        chk("wreq_when_full", 32'(WREQ & f), 0);
        if (WREQ) begin
            if (exp_q.size() == 0) chk("unexpected_write_depth", 0, 1);
            else begin
                e = exp_q.pop_front();
                chk("WD", 32'(WD), 32'(e.data));
                chk("ack", 32'(ack), 32'(1 << e.who));
            end
        end else begin
            chk("ack_idle", 32'(ack), 0);
            if (!busy) chk("WD_idle", 32'(WD), 0);
            if (exp_q.size() != 0) begin
                chk("missed_write", 32'(exp_q.size()), 0);
                exp_q.delete();
            end
        end
    end

    initial begin
        model_reset();
        #1;
        chk("init_gnt", 32'(gnt), 0);
        chk("init_wreq", 32'(WREQ), 0);
        chk("init_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (12) step(4'b0001, 0);
        repeat (25) step(4'b1111, 0);
        repeat (2) step(4'b0000, 0);
        repeat (4) step(4'b0100, 0);
        repeat (5) step(4'b0100, 1);
        repeat (6) step(4'b0100, 0);
        repeat (2) step(4'b0010, 0);
        step(4'b0000, 0);
        repeat (8) step(4'b0011, 0);
        repeat (3) step(4'b1000, 0);
        repeat (12) step(4'b1001, 0);
        repeat (2) step(4'b0000, 0);
        repeat (4) step(4'b0001, 0);
        repeat (3) step(4'b0001, 1);
        repeat (4) step(4'b0001, 0);
        repeat (3) step(4'b1111, 0);
        reset_pulse();
        repeat (10) step(4'b0110, 0);
        repeat (400) begin
            r  = ($urandom_range(0, 3) == 0) ? N'($urandom) : req;
            ff = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 99) == 0) reset_pulse();
            step(r, ff);
        end
        repeat (3) step(4'b0000, 0);
        @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the single write port of the fifo block (WREQ/WD/f) among N_REQ producers.
- Sits between the producer agents and the fifo write side, in the same clock domain as clkw.
- Grants one producer at a time, lets it write a bounded burst, honours fifo full (f), then rotates priority.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..16.
- DW, 8: data width; must equal the fifo WD width.
- MAX_BURST, 4: maximum words accepted per grant; legal range 1..255.

Ports:
- clk  input  1: clock; drives the fifo clkw side.
- rst  input  1: asynchronous, active-high reset.
- req  input  N_REQ: per-requester write request; held while the requester has data.
- req_wd  input  N_REQ*DW: per-requester write data; slice i = bits [i*DW +: DW].
- ack  output  N_REQ: one-hot pulse; the word on slice i is accepted this cycle.
- gnt  output  N_REQ: one-hot registered grant; zero when idle.
- busy  output  1: 1 while in GRANT.
- WREQ  output  1: fifo write request.
- WD  output  DW: fifo write data.
- f  input  1: fifo full flag.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, owner=0, cnt=0.
  - gnt=0, busy=0, WREQ=0, ack=0, WD=0.
  - Outputs clear immediately, without waiting for a clock edge.
- State IDLE:
  - WREQ=0, ack=0, WD=0.
  - If req!=0: owner <= first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ. Then cnt<=0, gnt<=onehot(owner), state<=GRANT.
  - If req==0: remain in IDLE.
  - Arbitration latency: req rising to first possible WREQ is 1 cycle.
- State GRANT:
  - WREQ = req[owner] & ~f (combinational from registered state).
  - WD = req_wd slice[owner].
  - ack[owner] = WREQ; all other ack bits are 0.
  - Write edge (WREQ=1): cnt<=cnt+1. If cnt==MAX_BURST-1, release.
  - Full stall (req[owner]=1, f=1): no write, cnt holds, grant holds indefinitely. There is no timeout.
  - Requester drop (req[owner]=0): release; no write that cycle.
  - Release: state<=IDLE, gnt<=0, rr_ptr<=(owner+1) mod N_REQ, cnt<=0.
  - There is always one IDLE bubble between consecutive grants. Max throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Boundaries:
  - Burst limit: the MAX_BURST-th write and the release happen on the same edge.
  - f and last word: if f rises the cycle the last word would be written, no write occurs and the grant holds.
  - Wrap-around: owner=N_REQ-1 gives rr_ptr=0.
  - Requests arriving during GRANT are ignored until the next IDLE.
  - With a single active requester, it is re-granted after each one-cycle bubble.
  - Reset mid-burst: a word presented on the edge where rst asserts is not written.
- Widths:
  - cnt is clog2(MAX_BURST+1) bits.
  - owner and rr_ptr are clog2(N_REQ) bits.
  - Modulo uses an explicit compare to N_REQ-1 (N_REQ need not be a power of 2).
- Invariants:
  - gnt is one-hot or zero.
  - ack is a subset of gnt.
  - WREQ never asserts when f=1.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, GRANT}.
  - Default constants for DW and MAX_BURST.
  - A function onehot(idx).
- Sub-module rr_pick: combinational rotating-priority encoder.
  - Inputs: req, rr_ptr.
  - Outputs: idx, found.
- The FSM, counter and write-port mux live in the top module.

Test Plan:
- Reset mid-burst: rst pulse during a burst -> gnt, WREQ, ack all 0 immediately; rr_ptr=0 afterwards; next grant goes to the lowest active index.
- Single requester, burst limit: req=0001, f=0, MAX_BURST=4 -> gnt=0001 after 1 cycle; 4 consecutive WREQ with WD=req_wd[7:0]; 1 idle cycle; gnt=0001 again.
- Rotation: req=1111 held, f=0 -> grants 0,1,2,3,0; each grant writes exactly 4 words; the fifo captures 16 words in requester order.
- Full stall: during a grant to 2, after 2 writes, force f=1 for 5 cycles -> WREQ=0, gnt=0100 held; after f drops, exactly 2 more writes, then release.
- Early drop: requester 1 lowers req after 1 write -> release next edge, rr_ptr=2; req=0011 then grants 0 before 1.
- Wrap and full-at-last-word: req=1000 then 1001 -> after 3 is served, 0 is granted. Separately, f=1 on the MAX_BURST-th cycle -> no write, grant held until f=0.
